// File: rtl/demux_pkg.sv
// Shared defaults and destination encoding for the 1-to-2 stream demultiplexer.
package demux_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_CNT_W  = 16;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_e;

endpackage

// File: rtl/demux_1x2_if.sv
// Stream bundle of demux_1x2: one input stream, two output streams and the mode select.
// slave is the demultiplexer's view, master is the view of the surrounding producer/consumers.
interface demux_1x2_if
    import demux_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
);

    logic [DATA_W-1:0] Din;
    logic              S;
    logic              in_valid;
    logic              in_ready;
    logic              alt_mode;

    logic [DATA_W-1:0] outA_data;
    logic              outA_valid;
    logic              outA_ready;

    logic [DATA_W-1:0] outB_data;
    logic              outB_valid;
    logic              outB_ready;

    modport slave (
        input  Din, S, in_valid, alt_mode, outA_ready, outB_ready,
        output in_ready, outA_data, outA_valid, outB_data, outB_valid
    );

    modport master (
        output Din, S, in_valid, alt_mode, outA_ready, outB_ready,
        input  in_ready, outA_data, outA_valid, outB_data, outB_valid
    );

endinterface

// File: rtl/demux_1x2_out_slot.sv
// One-entry registered output slot with valid/ready; data is kept after a drain.
module out_slot
    import demux_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] din,
    input  logic              ready,
    output logic              valid,
    output logic [DATA_W-1:0] data
);

    // A load wins over a drain so that drain+load in one cycle keeps the slot full.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= din;
        end else if (ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/demux_1x2.sv
// Stream demultiplexer: routes each accepted word to slot A or B by S or by ping-pong pointer.
// Optional saturating handshake counters cntA/cntB are built when DEMUX_STATS_EN is defined.
module demux_1x2
    import demux_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
`ifdef DEMUX_STATS_EN
    , parameter int CNT_W = DEF_CNT_W
`endif
) (
    input  logic         clk,
    input  logic         rst,
    demux_1x2_if.slave   bus,
    output logic         ptr
`ifdef DEMUX_STATS_EN
    , output logic [CNT_W-1:0] cntA
    , output logic [CNT_W-1:0] cntB
`endif
);

    port_e             dest;
    logic              destFree;
    logic              inReady;
    logic              accept;
    logic              loadA;
    logic              loadB;
    logic              aValid;
    logic              bValid;
    logic [DATA_W-1:0] aData;
    logic [DATA_W-1:0] bData;

    assign dest = bus.alt_mode ? port_e'(ptr) : port_e'(bus.S);

    // Head-of-line: only the addressed slot decides whether the input may advance.
    always_comb begin
        destFree = 1'b0;
        if (dest == PORT_A) begin
            destFree = !aValid || bus.outA_ready;
        end else begin
            destFree = !bValid || bus.outB_ready;
        end
    end

    assign inReady      = !rst && destFree;
    assign bus.in_ready = inReady;
    assign accept       = bus.in_valid && inReady;
    assign loadA        = accept && (dest == PORT_A);
    assign loadB        = accept && (dest == PORT_B);

    out_slot #(.DATA_W(DATA_W)) slotA (
        .clk   (clk),
        .rst   (rst),
        .load  (loadA),
        .din   (bus.Din),
        .ready (bus.outA_ready),
        .valid (aValid),
        .data  (aData)
    );

    out_slot #(.DATA_W(DATA_W)) slotB (
        .clk   (clk),
        .rst   (rst),
        .load  (loadB),
        .din   (bus.Din),
        .ready (bus.outB_ready),
        .valid (bValid),
        .data  (bData)
    );

    assign bus.outA_valid = aValid;
    assign bus.outA_data  = aData;
    assign bus.outB_valid = bValid;
    assign bus.outB_data  = bData;

    // The pointer only advances on accepts made in alternate mode.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= 1'b0;
        end else if (accept && bus.alt_mode) begin
            ptr <= ~ptr;
        end
    end

`ifdef DEMUX_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            cntA <= '0;
            cntB <= '0;
        end else begin
            if (aValid && bus.outA_ready && (cntA != '1)) begin
                cntA <= cntA + CNT_W'(1);
            end
            if (bValid && bus.outB_ready && (cntB != '1)) begin
                cntB <= cntB + CNT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_demux_1x2.sv
// Self-checking bench for demux_1x2: directed scenarios plus constrained-random traffic
// compared against a queue-based reference model. Define DEMUX_STATS_EN to cover the counters.
module tb_demux_1x2;

    logic clk = 1'b0;
    logic rst;
    logic ptr;
`ifdef DEMUX_STATS_EN
    logic [15:0] cntA;
    logic [15:0] cntB;
`endif

    demux_1x2_if #(.DATA_W(32)) bus ();

    demux_1x2 #(.DATA_W(32)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .ptr  (ptr)
`ifdef DEMUX_STATS_EN
        , .cntA (cntA)
        , .cntB (cntB)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: words accepted but not yet delivered, per output, in order.
    logic [31:0] qA[$];
    logic [31:0] qB[$];
    logic [31:0] heldA = '0;
    logic [31:0] heldB = '0;
    logic        mPtr = 1'b0;
    int unsigned mCntA = 0;
    int unsigned mCntB = 0;
    logic        armed = 1'b0;
    logic        lastAccepted = 1'b0;
    logic [31:0] gotA[$];
    logic [31:0] gotB[$];

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
        end
    endtask

    function automatic logic modelReady();
        logic d;
        logic full;
        logic rdy;
        d    = bus.alt_mode ? mPtr : bus.S;
        full = d ? (qB.size() != 0) : (qA.size() != 0);
        rdy  = d ? bus.outB_ready : bus.outA_ready;
        return !rst && (!full || rdy);
    endfunction

    // One clock: drive inputs, check everything at the falling edge, advance the model at the rising edge.
    task automatic applyStimulus(input logic r, input logic [31:0] din, input logic s, input logic v,
                                 input logic alt, input logic ra, input logic rb);
        logic expRdy;
        logic d;
        logic acc;
        rst            = r;
        bus.Din        = din;
        bus.S          = s;
        bus.in_valid   = v;
        bus.alt_mode   = alt;
        bus.outA_ready = ra;
        bus.outB_ready = rb;
        @(negedge clk);
        expRdy = modelReady();
        if (armed) begin
            checkOutput("in_ready", bus.in_ready, expRdy);
            checkOutput("outA_valid", bus.outA_valid, qA.size() != 0);
            checkOutput("outA_data", bus.outA_data, (qA.size() != 0) ? qA[0] : heldA);
            checkOutput("outB_valid", bus.outB_valid, qB.size() != 0);
            checkOutput("outB_data", bus.outB_data, (qB.size() != 0) ? qB[0] : heldB);
            checkOutput("ptr", ptr, mPtr);
`ifdef DEMUX_STATS_EN
            checkOutput("cntA", cntA, mCntA);
            checkOutput("cntB", cntB, mCntB);
`endif
        end
        if (bus.outA_valid === 1'b1 && ra) gotA.push_back(bus.outA_data);
        if (bus.outB_valid === 1'b1 && rb) gotB.push_back(bus.outB_data);
        @(posedge clk);
        d   = alt ? mPtr : s;
        acc = v && expRdy;
        lastAccepted = acc;
        if (r) begin
            qA.delete();
            qB.delete();
            heldA = '0;
            heldB = '0;
            mPtr  = 1'b0;
            mCntA = 0;
            mCntB = 0;
            armed = 1'b1;
        end else begin
            if (qA.size() != 0 && ra) begin
                heldA = qA.pop_front();
                if (mCntA < 65535) mCntA++;
            end
            if (qB.size() != 0 && rb) begin
                heldB = qB.pop_front();
                if (mCntB < 65535) mCntB++;
            end
            if (acc) begin
                if (d) qB.push_back(din);
                else   qA.push_back(din);
                if (alt) mPtr = ~mPtr;
            end
        end
        #1;
    endtask

    initial begin
        logic [31:0] curDin;
        logic        curSel;
        logic        curValid;
        logic        curAlt;
        rst            = 1'b1;
        bus.Din        = '0;
        bus.S          = 1'b0;
        bus.in_valid   = 1'b0;
        bus.alt_mode   = 1'b0;
        bus.outA_ready = 1'b0;
        bus.outB_ready = 1'b0;

        // Reset held two cycles, then release with both slots empty.
        applyStimulus(1, 32'h0, 0, 0, 0, 1, 1);
        applyStimulus(1, 32'h0, 0, 1, 0, 1, 1);
        checkOutput("rst_outA_valid", bus.outA_valid, 0);
        checkOutput("rst_outB_valid", bus.outB_valid, 0);
        checkOutput("rst_in_ready", bus.in_ready, 0);
        checkOutput("rst_ptr", ptr, 0);
        applyStimulus(0, 32'h0, 0, 0, 0, 1, 1);
        checkOutput("rel_in_ready", bus.in_ready, 1);

        // Explicit routing.
        applyStimulus(0, 32'h000000AA, 0, 1, 0, 1, 1);
        checkOutput("route_A_data", bus.outA_data, 32'hAA);
        checkOutput("route_A_valid", bus.outA_valid, 1);
        checkOutput("route_B_idle", bus.outB_valid, 0);
        applyStimulus(0, 32'h00000055, 1, 1, 0, 1, 1);
        checkOutput("route_B_data", bus.outB_data, 32'h55);
        checkOutput("route_B_valid", bus.outB_valid, 1);
        applyStimulus(0, 32'h0, 0, 0, 0, 1, 1);

        // Backpressure on A with a second word waiting for the same slot.
        applyStimulus(0, 32'h11, 0, 1, 0, 0, 1);
        checkOutput("bp_hold_data", bus.outA_data, 32'h11);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 32'h22, 0, 1, 0, 0, 1);
            checkOutput("bp_stall", bus.in_ready, 0);
        end
        applyStimulus(0, 32'h22, 0, 1, 0, 1, 1);
        checkOutput("bp_swap_data", bus.outA_data, 32'h22);
        checkOutput("bp_swap_valid", bus.outA_valid, 1);
        applyStimulus(0, 32'h0, 0, 0, 0, 1, 1);

        // Alternate mode, back-to-back words.
        gotA.delete();
        gotB.delete();
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(0, 32'(i), 0, 1, 1, 1, 1);
            checkOutput("alt_accepted", lastAccepted, 1);
        end
        applyStimulus(0, 32'h0, 0, 0, 1, 1, 1);
        applyStimulus(0, 32'h0, 0, 0, 1, 1, 1);
        checkOutput("alt_ptr_end", ptr, 0);
        checkOutput("alt_A_count", gotA.size(), 2);
        checkOutput("alt_B_count", gotB.size(), 2);
        if (gotA.size() == 2) begin
            checkOutput("alt_A0", gotA[0], 1);
            checkOutput("alt_A1", gotA[1], 3);
        end
        if (gotB.size() == 2) begin
            checkOutput("alt_B0", gotB[0], 2);
            checkOutput("alt_B1", gotB[1], 4);
        end

        // Random traffic; a stalled word keeps Din and S stable until accepted.
        curDin   = $urandom;
        curSel   = 1'($urandom);
        curValid = 1'b0;
        curAlt   = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if (!(curValid && !lastAccepted)) begin
                curDin   = $urandom;
                curSel   = 1'($urandom);
                curValid = ($urandom_range(0, 3) != 0);
            end
            if ($urandom_range(0, 7) == 0) curAlt = ~curAlt;
            applyStimulus(($urandom_range(0, 99) == 0), curDin, curSel, curValid, curAlt,
                          ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 7));
        end

        // Reset while slot A holds an undelivered word.
        applyStimulus(0, 32'h0, 0, 0, 0, 1, 1);
        applyStimulus(0, 32'h0, 0, 0, 0, 1, 1);
        applyStimulus(0, 32'h77, 0, 1, 0, 0, 1);
        checkOutput("mid_full", bus.outA_valid, 1);
        checkOutput("mid_data", bus.outA_data, 32'h77);
        gotA.delete();
        applyStimulus(1, 32'h0, 0, 0, 0, 0, 1);
        checkOutput("mid_rst_valid", bus.outA_valid, 0);
        checkOutput("mid_rst_ptr", ptr, 0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 32'h0, 0, 0, 0, 1, 1);
        checkOutput("mid_not_delivered", gotA.size(), 0);

`ifdef DEMUX_STATS_EN
        // Counter saturation on A, small count on B, then reset.
        applyStimulus(1, 32'h0, 0, 0, 0, 1, 1);
        for (int i = 0; i < 70000; i++) applyStimulus(0, 32'(i), 0, 1, 0, 1, 1);
        for (int i = 0; i < 3; i++) applyStimulus(0, 32'(i), 1, 1, 0, 1, 1);
        applyStimulus(0, 32'h0, 0, 0, 0, 1, 1);
        applyStimulus(0, 32'h0, 0, 0, 0, 1, 1);
        checkOutput("stat_cntA_sat", cntA, 16'hFFFF);
        checkOutput("stat_cntB", cntB, 3);
        applyStimulus(1, 32'h0, 0, 0, 0, 1, 1);
        checkOutput("stat_rst_cntA", cntA, 0);
        checkOutput("stat_rst_cntB", cntB, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
